csr_exec: RTL
=============

Name: csr_exec

Overview:
- Execute-stage CSR/trap unit, directly downstream of the cycle/instret counter block.
- Decodes Zicsr instructions and performs read-modify-write on the machine-mode CSRs.
- Muxes the counter block's 32-bit read data onto the rd writeback path.
- Handles ECALL/MRET/WFI and interrupt entry, issuing a one-cycle PC redirect to fetch.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- RESET_MTVEC, 32'h0000_0000, mtvec value after reset

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- instr_valid  in  1  instr/pc/rs1_data valid this cycle
- instr  in  32  instruction in EX (same word driven to counter block)
- pc  in  32  PC of instr
- rs1_data  in  32  forwarded rs1 value
- ctr_rdata  in  32  counter block read data for instr (0xC00/C80/C02/C82)
- irq_ext  in  1  machine external interrupt level
- irq_timer  in  1  machine timer interrupt level
- csr_rdata  out  32  old CSR value to rd
- stall  out  1  hold upstream pipeline
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target
- illegal  out  1  illegal CSR access detected (combinational)

Behaviour:
- Reset:
  - mstatus, mie, mepc, mcause, mscratch = 0; mtvec = RESET_MTVEC.
  - State IDLE.
  - Outputs stall, redirect_valid, illegal = 0; redirect_pc = 0; csr_rdata = 0.
- CSR instruction decode: opcode 7'b1110011, funct3 != 000.
  - Operations: 001 RW, 010 RS, 011 RC; 101/110/111 are immediate forms with zimm = {27'b0, instr[19:15]}.
  - Address = instr[31:20].
- Supported CSRs:
  - 0x300 mstatus: only MIE bit 3 and MPIE bit 7 are writable; all other bits read 0.
  - 0x304 mie: only MTIE bit 7 and MEIE bit 11 are writable.
  - 0x305 mtvec: bits [1:0] read 0.
  - 0x340 mscratch.
  - 0x341 mepc: bits [1:0] read 0.
  - 0x342 mcause.
  - 0x344 mip: read-only; bit 7 = irq_timer, bit 11 = irq_ext.
  - 0xC00/0xC80/0xC02/0xC82 read-only: csr_rdata = ctr_rdata.
- Read path: csr_rdata is combinational and returns the pre-write value. It is 0 when no valid CSR instruction is present.
- Write suppression: no write for RS/RC (register or immediate form) when instr[19:15] = 0.
- Write commit: the write commits at the clock edge of the valid cycle.
- Illegal access: asserted for an unsupported address, or for a write to address[11:10] = 2'b11. It causes an illegal trap (mcause = 2); no write occurs and csr_rdata = 0.
- Special instructions:
  - ECALL 32'h0000_0073.
  - MRET 32'h3020_0073.
  - WFI 32'h1050_0073.
- Interrupt pending: int_pend = mstatus.MIE & ((mie.MEIE & irq_ext) | (mie.MTIE & irq_timer)).
- Trap check, in IDLE with instr_valid. Priority: external interrupt > timer interrupt > illegal > ECALL.
  - mcause values: ext = 32'h8000_000B, timer = 32'h8000_0007, illegal = 2, ecall = 11.
  - On trap: mepc <= pc; MPIE <= MIE; MIE <= 0; the instruction's CSR write is suppressed; go to REDIR.
  - Target is mtvec & ~3.
- MRET in IDLE: MIE <= MPIE; MPIE <= 1; go to REDIR with target mepc.
- FSM states:
  - IDLE: normal operation.
  - REDIR: exactly 1 cycle with redirect_valid = 1 and redirect_pc = latched target; instr_valid is ignored; then IDLE.
  - WFI: stall = 1 while (mie.MEIE & irq_ext | mie.MTIE & irq_timer) = 0, regardless of mstatus.MIE. On wake, return to IDLE with stall = 0 in the same cycle the wake condition is seen.
- WFI entry: WFI in IDLE with no trap pending goes to WFI. If int_pend is already 1, the interrupt is taken instead.
- redirect_pc holds its last value when redirect_valid = 0.
- rst asserted in any state returns to IDLE at the next edge, clearing all CSRs.

Optional Feature:
- Macro: CSR_VECTORED_EN.
- Defined:
  - mtvec[1:0] = 01 is writable and readable.
  - When mtvec[1:0] = 01, an interrupt trap targets (mtvec & ~3) + 4*cause[4:0]; exceptions still use the base.
- Undefined: mtvec[1:0] is hardwired to 0, writes to those bits are ignored, and all traps use the base.

Decomposition:
- csr_pkg contains:
  - CSR address localparams.
  - funct3 op encodings.
  - ECALL/MRET/WFI encodings.
  - mcause constants.
  - mstatus/mie bit indices.
  - typedef enum logic [1:0] {IDLE, REDIR, WFI} csr_state_e.
- Sub-module csr_decode: purely combinational. Takes instr; outputs is_csr, op, addr, src_is_imm, wr_en, is_ecall, is_mret, is_wfi, addr_ok, read_only.

Test Plan:
- CSRRW x1, mscratch, rs1 = 32'hDEAD_BEEF, then CSRRS rs1 = 0 → second csr_rdata = 32'hDEAD_BEEF; mscratch is unchanged.
- Write mtvec = 32'h0000_0100, then ECALL at pc = 32'h80 → next cycle redirect_valid = 1, redirect_pc = 32'h100, mepc = 32'h80, mcause = 11.
- mstatus.MIE = 1, mie.MEIE = 1, irq_ext = 1 with valid instr at pc = 32'h40 → mcause = 32'h8000_000B, MIE = 0, MPIE = 1; MRET then redirects to 32'h40 with MIE = 1.
- CSRRW to 0xC00 → illegal = 1, mcause = 2, no write. CSRRS 0xC80 with rs1 = x0 and ctr_rdata = 32'h5 → csr_rdata = 5, illegal = 0.
- WFI with mie.MTIE = 1, MIE = 0 → stall held high for 10 cycles; irq_timer = 1 → stall = 0 in the same cycle, no redirect.
- With CSR_VECTORED_EN defined and mtvec = 32'h101, timer interrupt → redirect_pc = 32'h11C.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, encodings, causes and FSM state for csr_exec
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct3[1:0]; funct3[2] selects the zimm source
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
  localparam logic [31:0] INSTR_MRET  = 32'h3020_0073;
  localparam logic [31:0] INSTR_WFI   = 32'h1050_0073;

  localparam logic [31:0] MCAUSE_EXT     = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_TIMER   = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] MCAUSE_ECALL   = 32'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
  localparam logic [31:0] MIE_MASK     = 32'h0000_0880;

  typedef enum logic [1:0] {IDLE, REDIR, WFI} csr_state_e;

  function automatic logic addr_supported(input logic [11:0] a);
    case (a)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MIP,
      CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH: addr_supported = 1'b1;
      default: addr_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_decode.sv
// rtl/csr_decode.sv - combinational Zicsr / ECALL / MRET / WFI decoder
module csr_decode
  import csr_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_csr,
  output logic [1:0]  op,
  output logic [11:0] addr,
  output logic        src_is_imm,
  output logic        wr_en,
  output logic        is_ecall,
  output logic        is_mret,
  output logic        is_wfi,
  output logic        addr_ok,
  output logic        read_only
);

  assign op         = instr[13:12];
  assign src_is_imm = instr[14];
  assign addr       = instr[31:20];

  // funct3 = 100 is reserved and is not treated as a CSR access
  assign is_csr = (instr[6:0] == OPC_SYSTEM) && (op != 2'b00);

  // RS/RC with a zero rs1 field (or zimm) are pure reads
  assign wr_en = is_csr && ((op == OP_RW) || (instr[19:15] != 5'd0));

  assign is_ecall  = (instr == INSTR_ECALL);
  assign is_mret   = (instr == INSTR_MRET);
  assign is_wfi    = (instr == INSTR_WFI);
  assign addr_ok   = addr_supported(addr);
  assign read_only = (addr[11:10] == 2'b11);

endmodule

// File: rtl/csr_exec.sv
// rtl/csr_exec.sv - execute-stage machine CSR / trap unit with one-cycle fetch redirect
// Build option CSR_VECTORED_EN enables vectored interrupt targets via mtvec[1:0] = 01.
module csr_exec
  import csr_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] ctr_rdata,
  input  logic            irq_ext,
  input  logic            irq_timer,
  output logic [XLEN-1:0] csr_rdata,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal
);

`ifdef CSR_VECTORED_EN
  localparam logic [31:0] MTVEC_RST = (RESET_MTVEC[1:0] == 2'b01) ? RESET_MTVEC
                                                                  : (RESET_MTVEC & ~32'h3);
`else
  localparam logic [31:0] MTVEC_RST = RESET_MTVEC & ~32'h3;
`endif

  logic        is_csr, src_is_imm, wr_en, is_ecall, is_mret, is_wfi, addr_ok, read_only;
  logic [1:0]  op;
  logic [11:0] addr;

  csr_decode u_decode (
    .instr      (instr),
    .is_csr     (is_csr),
    .op         (op),
    .addr       (addr),
    .src_is_imm (src_is_imm),
    .wr_en      (wr_en),
    .is_ecall   (is_ecall),
    .is_mret    (is_mret),
    .is_wfi     (is_wfi),
    .addr_ok    (addr_ok),
    .read_only  (read_only)
  );

  csr_state_e  state_q, state_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic        in_idle, instr_go, csr_valid, illegal_acc;
  logic        int_ext, int_tmr, take_int, take_trap, wake;
  logic [31:0] mip_val, csr_old, src_val, wdata, trap_cause, trap_target, mtvec_base;

  assign in_idle     = (state_q == IDLE);
  assign instr_go    = instr_valid && in_idle;
  assign csr_valid   = instr_go && is_csr;
  assign illegal_acc = csr_valid && (!addr_ok || (read_only && wr_en));
  assign illegal     = illegal_acc;

  assign int_ext  = mstatus_q[MSTATUS_MIE] && mie_q[MIE_MEIE] && irq_ext;
  assign int_tmr  = mstatus_q[MSTATUS_MIE] && mie_q[MIE_MTIE] && irq_timer;
  assign take_int = int_ext || int_tmr;
  // WFI wakes on any locally enabled source, even with global MIE clear
  assign wake     = (mie_q[MIE_MEIE] && irq_ext) || (mie_q[MIE_MTIE] && irq_timer);
  assign take_trap = instr_go && (take_int || illegal_acc || is_ecall);

  always_comb begin
    mip_val           = 32'h0;
    mip_val[MIE_MTIE] = irq_timer;
    mip_val[MIE_MEIE] = irq_ext;
  end

  always_comb begin
    csr_old = 32'h0;
    case (addr)
      CSR_MSTATUS:  csr_old = mstatus_q;
      CSR_MIE:      csr_old = mie_q;
      CSR_MTVEC:    csr_old = mtvec_q;
      CSR_MSCRATCH: csr_old = mscratch_q;
      CSR_MEPC:     csr_old = mepc_q;
      CSR_MCAUSE:   csr_old = mcause_q;
      CSR_MIP:      csr_old = mip_val;
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: csr_old = ctr_rdata;
      default:      csr_old = 32'h0;
    endcase
  end

  assign csr_rdata = (csr_valid && !illegal_acc) ? csr_old : 32'h0;

  assign src_val = src_is_imm ? {27'b0, instr[19:15]} : rs1_data;

  always_comb begin
    wdata = csr_old;
    case (op)
      OP_RW:   wdata = src_val;
      OP_RS:   wdata = csr_old | src_val;
      OP_RC:   wdata = csr_old & ~src_val;
      default: wdata = csr_old;
    endcase
  end

  always_comb begin
    if (int_ext)          trap_cause = MCAUSE_EXT;
    else if (int_tmr)     trap_cause = MCAUSE_TIMER;
    else if (illegal_acc) trap_cause = MCAUSE_ILLEGAL;
    else                  trap_cause = MCAUSE_ECALL;
  end

  assign mtvec_base = mtvec_q & ~32'h3;

  always_comb begin
    trap_target = mtvec_base;
`ifdef CSR_VECTORED_EN
    if (take_int && (mtvec_q[1:0] == 2'b01))
      trap_target = mtvec_base + {25'b0, trap_cause[4:0], 2'b00};
`endif
  end

  always_comb begin
    state_d    = state_q;
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    redir_pc_d = redir_pc_q;
    case (state_q)
      IDLE: begin
        if (take_trap) begin
          mepc_d                 = pc & ~32'h3;
          mcause_d               = trap_cause;
          mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
          mstatus_d[MSTATUS_MIE]  = 1'b0;
          redir_pc_d             = trap_target;
          state_d                = REDIR;
        end else if (instr_go && is_mret) begin
          mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
          mstatus_d[MSTATUS_MPIE] = 1'b1;
          redir_pc_d             = mepc_q;
          state_d                = REDIR;
        end else if (instr_go && is_wfi) begin
          state_d = WFI;
        end else if (csr_valid && wr_en) begin
          case (addr)
            CSR_MSTATUS:  mstatus_d  = wdata & MSTATUS_MASK;
            CSR_MIE:      mie_d      = wdata & MIE_MASK;
`ifdef CSR_VECTORED_EN
            CSR_MTVEC:    mtvec_d    = (wdata & ~32'h3) | {31'b0, (wdata[1:0] == 2'b01)};
`else
            CSR_MTVEC:    mtvec_d    = wdata & ~32'h3;
`endif
            CSR_MSCRATCH: mscratch_d = wdata;
            CSR_MEPC:     mepc_d     = wdata & ~32'h3;
            CSR_MCAUSE:   mcause_d   = wdata;
            default:      ;
          endcase
        end
      end
      REDIR:   state_d = IDLE;
      WFI:     if (wake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mstatus_q  <= 32'h0;
      mie_q      <= 32'h0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      redir_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign redirect_valid = (state_q == REDIR);
  assign redirect_pc    = redir_pc_q;
  assign stall          = (state_q == WFI) && !wake;

endmodule
